// File: rtl/hidden_spike_arbiter.sv
// hidden_spike_arbiter
// Shares the hidden layer's single address-event output among N_NEURON
// neurons. Pending spike lines are scanned round-robin. The winner's index
// is sent downstream over a valid/ready handshake, and then that neuron gets
// a one-cycle ack. The block also produces the layer-wide refractory tick
// and keeps a saturating count of accepted events.
//
// Ports:
//   clk          rising-edge system clock
//   resetn       asynchronous reset, active HIGH (name kept from the codebase)
//   enable       allows new grants and runs the tick prescaler
//   spike_req    per-neuron spike level, held until acked
//   ack_out      one-hot ack pulse to the granted neuron
//   timer_en     one-cycle tick to all neurons every TICK_DIV cycles
//   ev_valid     output event valid
//   ev_ready     downstream ready
//   ev_addr      granted neuron index, zero-extended
//   busy         high whenever the arbiter is not idle
//   event_count  saturating count of accepted events
module hidden_spike_arbiter #(
  parameter int N_NEURON = 16,
  parameter int ADDR_W   = 8,
  parameter int TICK_DIV = 100,
  parameter int CNT_W    = 16
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                enable,
  input  logic [N_NEURON-1:0] spike_req,
  output logic [N_NEURON-1:0] ack_out,
  output logic                timer_en,
  output logic                ev_valid,
  input  logic                ev_ready,
  output logic [ADDR_W-1:0]   ev_addr,
  output logic                busy,
  output logic [CNT_W-1:0]    event_count
);

  localparam int IDX_W  = $clog2(N_NEURON);
  localparam int TICK_W = $clog2(TICK_DIV);

  typedef enum logic [1:0] {IDLE, SEND, ACK, SETTLE} state_t;

  state_t              state;
  state_t              state_next;
  logic [IDX_W-1:0]    rr_ptr;
  logic [IDX_W-1:0]    grant_idx;
  logic [IDX_W-1:0]    winner;
  logic [IDX_W-1:0]    rot_idx;
  logic [IDX_W:0]      idx_sum;
  logic [N_NEURON-1:0] req_rot;
  logic [TICK_W-1:0]   tick_cnt;
  logic                any_req;
  logic                accept;

  assign any_req = |spike_req;
  assign accept  = (state == SEND) && ev_ready;

  // Winner select. The request vector is rotated so that rr_ptr lands at
  // bit 0, and the lowest set bit is found. The offset is then added back
  // modulo N_NEURON. This gives "lowest index >= rr_ptr, else wrap to the
  // lowest overall" without a second search.
  always_comb begin
    req_rot = N_NEURON'({spike_req, spike_req} >> rr_ptr);
    rot_idx = '0;
    for (int k = N_NEURON - 1; k >= 0; k--) begin
      if (req_rot[k]) rot_idx = IDX_W'(k);
    end
    idx_sum = {1'b0, rr_ptr} + {1'b0, rot_idx};
    if (idx_sum >= (IDX_W+1)'(N_NEURON)) idx_sum = idx_sum - (IDX_W+1)'(N_NEURON);
    winner = idx_sum[IDX_W-1:0];
  end

  // State register
  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic. Once an event is offered, it always completes: enable
  // only gates the start of a grant.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (enable && any_req) state_next = SEND;
      SEND:    if (ev_ready)          state_next = ACK;
      ACK:                            state_next = SETTLE;
      SETTLE:                         state_next = IDLE;
      default:                        state_next = IDLE;
    endcase
  end

  // Outputs are decoded from registered state and grant_idx only. An async
  // reset therefore drops ev_valid and ack immediately.
  always_comb begin
    ack_out  = '0;
    ev_valid = 1'b0;
    ev_addr  = '0;
    busy     = (state != IDLE);
    case (state)
      SEND: begin
        ev_valid = 1'b1;
        ev_addr  = ADDR_W'(grant_idx);
      end
      ACK:     ack_out[grant_idx] = 1'b1;
      default: ;
    endcase
  end

  // Grant capture, round-robin pointer, and saturating event counter. The
  // pointer moves past the winner only when the event is accepted.
  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      grant_idx   <= '0;
      rr_ptr      <= '0;
      event_count <= '0;
    end else begin
      if (state == IDLE && enable && any_req) grant_idx <= winner;
      if (accept) begin
        rr_ptr <= (grant_idx == IDX_W'(N_NEURON - 1)) ? '0 : grant_idx + IDX_W'(1);
        if (event_count != '1) event_count <= event_count + CNT_W'(1);
      end
    end
  end

  // Refractory tick prescaler. It is independent of the arbitration FSM, and
  // it freezes (it does not reset) while enable is low.
  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      tick_cnt <= '0;
      timer_en <= 1'b0;
    end else begin
      timer_en <= 1'b0;
      if (enable) begin
        if (tick_cnt == TICK_W'(TICK_DIV - 1)) begin
          tick_cnt <= '0;
          timer_en <= 1'b1;
        end else begin
          tick_cnt <= tick_cnt + TICK_W'(1);
        end
      end
    end
  end

endmodule
